// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: program loader writes in IDLE, sequential
// fetch with stall/redirect/halt in RUN, sticky FAULT on bad addresses.
// Optional feature macro: IMEM_FETCH_PERF_EN adds fetch_count/stall_count.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
`ifdef IMEM_FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        fault
);

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic                valid_nxt;
    logic                fault_nxt;
    logic                issue;

    // Misaligned or beyond the attached memory.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= ADDR_W'(MEM_DEPTH));
    endfunction

    // Next-state, datapath control and combinational memory/loader handshake.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        valid_nxt  = instr_valid;
        fault_nxt  = fault;
        issue      = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        load_ready = 1'b0;

        case (state)
            ST_IDLE: begin
                valid_nxt = 1'b0;
                if (load_valid) begin
                    load_ready = 1'b1;
                    mem_addr   = load_addr;
                    mem_wdata  = load_data;
                    if (addr_bad(load_addr)) begin
                        fault_nxt = 1'b1;
                        state_nxt = ST_FAULT;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
                // A simultaneous good load completes and start is still honoured.
                if (start && (state_nxt != ST_FAULT)) begin
                    pc_nxt    = RESET_PC;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_addr = pc;
                if (halt) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                end else if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    valid_nxt = 1'b0;
                end else if (addr_bad(pc)) begin
                    // Covers bad redirect targets and running off the end of memory.
                    fault_nxt = 1'b1;
                    valid_nxt = 1'b0;
                    state_nxt = ST_FAULT;
                end else if (!stall) begin
                    issue     = 1'b1;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc + ADDR_W'(4);
                end
            end
            default: begin
                valid_nxt = 1'b0;
            end
        endcase

        // Reset is synchronous, so the handshake must be masked explicitly.
        if (!rst_n) begin
            mem_we     = 1'b0;
            load_ready = 1'b0;
        end
    end

    // State register and registered fetch outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_valid <= valid_nxt;
            fault       <= fault_nxt;
            if (issue) begin
                instr    <= mem_rdata;
                instr_pc <= pc;
            end
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    // Saturating issue and stall counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state == ST_RUN) && stall && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: directed vector table, hand sequences for
// halt/reset/end-of-memory, and randomized stimulus against a rule-level model.
module tb_imem_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, halt, stall, redirect_valid, load_valid;
    logic [31:0] redirect_pc, load_addr, load_data;
    logic        load_ready, mem_we, instr_valid, fault;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, instr, instr_pc;
    logic        s_load_ready, s_mem_we, s_instr_valid, s_fault;
    logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata, s_instr, s_instr_pc;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count, s_fetch_count, s_stall_count;
`endif

    logic [31:0] mem [0:255];
    assign mem_rdata   = mem[mem_addr[9:2]];
    assign s_mem_rdata = mem[s_mem_addr[9:2]];

    // Instruction memory written only by the main instance.
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    imem_fetch_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc),
`ifdef IMEM_FETCH_PERF_EN
        .fetch_count(fetch_count), .stall_count(stall_count),
`endif
        .fault(fault)
    );

    imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(s_load_ready), .mem_addr(s_mem_addr), .mem_we(s_mem_we),
        .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .instr_valid(s_instr_valid),
        .instr(s_instr), .instr_pc(s_instr_pc),
`ifdef IMEM_FETCH_PERF_EN
        .fetch_count(s_fetch_count), .stall_count(s_stall_count),
`endif
        .fault(s_fault)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start, halt, stall, rv;
        logic [31:0] rpc;
        logic        lv;
        logic [31:0] la, ld;
        logic        e_lr, e_we, e_valid;
        logic [31:0] e_pc, e_instr;
        logic        e_fault;
    } vec_t;

    localparam logic [31:0] D0  = 32'h1111_0000;
    localparam logic [31:0] D1  = 32'h2222_0004;
    localparam logic [31:0] D2  = 32'h3333_0008;
    localparam logic [31:0] D3  = 32'h4444_000C;
    localparam logic [31:0] D40 = 32'h5555_0040;
    localparam logic [31:0] D44 = 32'h6666_0044;
    localparam logic [31:0] D10 = 32'h7777_0010;

    vec_t vt [18];

    function automatic vec_t mk(input logic st, input logic hl, input logic sl,
                                input logic rv, input logic [31:0] rpc,
                                input logic lv, input logic [31:0] la, input logic [31:0] ld,
                                input logic lr, input logic we, input logic v,
                                input logic [31:0] pc, input logic [31:0] ins, input logic f);
        vec_t r;
        r.start = st; r.halt = hl; r.stall = sl; r.rv = rv; r.rpc = rpc;
        r.lv = lv; r.la = la; r.ld = ld;
        r.e_lr = lr; r.e_we = we; r.e_valid = v; r.e_pc = pc; r.e_instr = ins; r.e_fault = f;
        return r;
    endfunction

    task automatic idle_inputs();
        start = 0; halt = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        load_valid = 0; load_addr = 0; load_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_mode = 0;   // 0 idle, 1 run, 2 fault
    logic [31:0] m_pc = 0, m_instr = 0, m_ipc = 0;
    logic        m_valid = 0, m_fault = 0;
    logic [31:0] mmem [0:255];
    longint      m_fc = 0, m_sc = 0;

    function automatic bit good(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 256);
    endfunction

    task automatic model_step(output logic e_lr, output logic e_we);
        bit bad_load;
        e_lr = rst_n && (m_mode == 0) && load_valid;
        e_we = e_lr && good(load_addr);
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_fault = 0;
            m_fc = 0; m_sc = 0;
            return;
        end
        if (m_mode == 1 && stall && m_sc < 64'hFFFF_FFFF) m_sc++;
        case (m_mode)
            0: begin
                bad_load = load_valid && !good(load_addr);
                if (e_we) mmem[load_addr / 4] = load_data;
                if (bad_load) begin m_mode = 2; m_fault = 1; end
                else if (start) begin m_mode = 1; m_pc = 0; end
            end
            1: begin
                if (halt) begin m_mode = 0; m_valid = 0; end
                else if (redirect_valid) begin m_pc = redirect_pc; m_valid = 0; end
                else if (!good(m_pc)) begin m_mode = 2; m_fault = 1; m_valid = 0; end
                else if (!stall) begin
                    m_valid = 1; m_ipc = m_pc; m_instr = mmem[m_pc / 4];
                    m_pc = m_pc + 4; m_fc++;
                end
            end
            default: m_valid = 0;
        endcase
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 39) == 0) return $urandom();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    initial begin
        logic e_lr, e_we;

        for (int i = 0; i < 256; i++) begin mem[i] = 0; mmem[i] = 0; end
        idle_inputs();

        // Reset with a pending load: no handshake, no write.
        rst_n = 0; load_valid = 1; load_addr = 32'h20; load_data = 32'hDEAD_BEEF;
        #1;
        chk("rst_load_ready", load_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        tick();
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_fault", fault, 0);
        rst_n = 1; idle_inputs();

        // Directed table: load, run, stall, redirect, bad redirect, fault.
        //              st hl sl rv rpc      lv la     ld          lr we v  pc     instr f
        vt[0]  = mk(0, 0, 0, 0, 0,       1, 32'h0,  D0,          1, 1, 0, 0,     0,    0);
        vt[1]  = mk(0, 0, 0, 0, 0,       1, 32'h4,  D1,          1, 1, 0, 0,     0,    0);
        vt[2]  = mk(0, 0, 0, 0, 0,       1, 32'h8,  D2,          1, 1, 0, 0,     0,    0);
        vt[3]  = mk(0, 0, 0, 0, 0,       1, 32'hC,  D3,          1, 1, 0, 0,     0,    0);
        vt[4]  = mk(0, 0, 0, 0, 0,       1, 32'h40, D40,         1, 1, 0, 0,     0,    0);
        vt[5]  = mk(1, 0, 0, 0, 0,       1, 32'h44, D44,         1, 1, 0, 0,     0,    0);
        vt[6]  = mk(0, 0, 0, 0, 0,       1, 32'h80, 32'hDEAD,    0, 0, 1, 32'h0, D0,   0);
        vt[7]  = mk(0, 0, 0, 0, 0,       0, 0,      0,           0, 0, 1, 32'h4, D1,   0);
        vt[8]  = mk(0, 0, 1, 0, 0,       0, 0,      0,           0, 0, 1, 32'h4, D1,   0);
        vt[9]  = mk(0, 0, 1, 0, 0,       0, 0,      0,           0, 0, 1, 32'h4, D1,   0);
        vt[10] = mk(0, 0, 1, 0, 0,       0, 0,      0,           0, 0, 1, 32'h4, D1,   0);
        vt[11] = mk(0, 0, 0, 0, 0,       0, 0,      0,           0, 0, 1, 32'h8, D2,   0);
        vt[12] = mk(0, 0, 1, 1, 32'h40,  0, 0,      0,           0, 0, 0, 0,     0,    0);
        vt[13] = mk(0, 0, 0, 0, 0,       0, 0,      0,           0, 0, 1, 32'h40, D40, 0);
        vt[14] = mk(0, 0, 0, 1, 32'h42,  0, 0,      0,           0, 0, 0, 0,     0,    0);
        vt[15] = mk(0, 0, 0, 0, 0,       0, 0,      0,           0, 0, 0, 0,     0,    1);
        vt[16] = mk(0, 0, 0, 0, 0,       1, 32'h0,  32'hBAD,     0, 0, 0, 0,     0,    1);
        vt[17] = mk(1, 0, 0, 0, 0,       0, 0,      0,           0, 0, 0, 0,     0,    1);

        for (int i = 0; i < 18; i++) begin
            start = vt[i].start; halt = vt[i].halt; stall = vt[i].stall;
            redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc;
            load_valid = vt[i].lv; load_addr = vt[i].la; load_data = vt[i].ld;
            #1;
            chk($sformatf("vec%0d_load_ready", i), load_ready, vt[i].e_lr);
            chk($sformatf("vec%0d_mem_we", i), mem_we, vt[i].e_we);
            tick();
            chk($sformatf("vec%0d_instr_valid", i), instr_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_fault", i), fault, vt[i].e_fault);
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_instr_pc", i), instr_pc, vt[i].e_pc);
                chk($sformatf("vec%0d_instr", i), instr, vt[i].e_instr);
            end
        end
        idle_inputs();
        chk("run_load_not_written", mem[32], 0);
        chk("fault_load_not_written", mem[0], D0);

        // Halt (with redirect) beats everything; restart refetches from RESET_PC.
        rst_n = 0; tick(); rst_n = 1;
        start = 1; tick(); start = 0;
        tick();
        chk("restart_valid", instr_valid, 1);
        chk("restart_pc", instr_pc, 0);
        halt = 1; redirect_valid = 1; redirect_pc = 32'h40; tick();
        halt = 0; redirect_valid = 0;
        chk("halt_valid", instr_valid, 0);
        chk("halt_fault", fault, 0);
        load_valid = 1; load_addr = 32'h10; load_data = D10;
        #1;
        chk("halt_idle_load_ready", load_ready, 1);
        chk("halt_idle_mem_we", mem_we, 1);
        tick(); load_valid = 0;
        chk("idle_load_written", mem[4], D10);
        start = 1; tick(); start = 0;
        tick();
        chk("rerun_pc0", instr_pc, 0);
        chk("rerun_instr0", instr, D0);
        tick();
        chk("rerun_pc4", instr_pc, 32'h4);

        // Reset mid-RUN with a pending load.
        rst_n = 0; load_valid = 1; load_addr = 32'h8; load_data = 32'h0BAD_0BAD;
        #1;
        chk("midrst_load_ready", load_ready, 0);
        chk("midrst_mem_we", mem_we, 0);
        tick();
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_instr", instr, 0);
        chk("midrst_instr_pc", instr_pc, 0);
        chk("midrst_fault", fault, 0);
`ifdef IMEM_FETCH_PERF_EN
        chk("midrst_fetch_count", fetch_count, 0);
        chk("midrst_stall_count", stall_count, 0);
`endif
        chk("midrst_no_write", mem[2], D2);
        rst_n = 1; idle_inputs();

        // Four-word instance runs off the end: 0x0..0xC issue, then fault.
        start = 1; tick(); start = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("small_valid%0d", k), s_instr_valid, 1);
            chk($sformatf("small_pc%0d", k), s_instr_pc, 32'(k * 4));
            chk($sformatf("small_fault%0d", k), s_fault, 0);
        end
        chk("small_instr3", s_instr, D3);
        #1;
        chk("small_no_write", s_mem_we, 0);
        tick();
        chk("small_end_fault", s_fault, 1);
        chk("small_end_valid", s_instr_valid, 0);
        tick();
        chk("small_end_valid_hold", s_instr_valid, 0);
        chk("small_end_pc_last", s_instr_pc, 32'hC);

        // Randomized run against the reference model.
        for (int i = 0; i < 256; i++) begin mem[i] = 0; mmem[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            start = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            halt = ($urandom_range(0, 29) == 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc = rand_addr();
            load_valid = 1'($urandom_range(0, 1));
            load_addr = rand_addr();
            load_data = $urandom();
            #1;
            model_step(e_lr, e_we);
            chk("rnd_load_ready", load_ready, e_lr);
            chk("rnd_mem_we", mem_we, e_we);
            tick();
            chk("rnd_instr_valid", instr_valid, m_valid);
            chk("rnd_fault", fault, m_fault);
            if (m_valid) begin
                chk("rnd_instr_pc", instr_pc, m_ipc);
                chk("rnd_instr", instr, m_instr);
            end
`ifdef IMEM_FETCH_PERF_EN
            chk("rnd_fetch_count", fetch_count, 32'(m_fc));
            chk("rnd_stall_count", stall_count, 32'(m_sc));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
